// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient} for the HI/LO register.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  input  logic                 annul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH:0]     work_q, work_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic [2*WIDTH:0]     shifted;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH:0]     iter;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  // Next-state, datapath step and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    // One restoring step: shift, trial-subtract from the upper WIDTH+1 bits
    shifted = work_q << 1;
    diff    = shifted[2*WIDTH:WIDTH] - {1'b0, dvs_q};
    if (diff[WIDTH]) begin
      iter = shifted;
    end else begin
      iter = {diff, shifted[WIDTH-1:1], 1'b1};
    end
    quo     = iter[WIDTH-1:0];
    rem     = iter[2*WIDTH-1:WIDTH];
    quo_fix = q_neg_q ? (-quo) : quo;
    rem_fix = r_neg_q ? (-rem) : rem;

    abs_a = (signed_div && opdata1[WIDTH-1]) ? (-opdata1) : opdata1;
    abs_b = (signed_div && opdata2[WIDTH-1]) ? (-opdata2) : opdata2;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          if (opdata2 == {WIDTH{1'b0}}) begin
            state_d = S_DIVZERO;
          end else begin
            state_d = S_ON;
            work_d  = {{(WIDTH+1){1'b0}}, abs_a};
            cnt_d   = {CNT_W{1'b0}};
            dvs_d   = abs_b;
            q_neg_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            r_neg_d = signed_div & opdata1[WIDTH-1];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          work_d = iter;
          cnt_d  = cnt_q + CNT_W'(1);
          // Last step: apply sign correction while loading the result
          if (cnt_d == CNT_W'(WIDTH)) begin
            state_d  = S_END;
            result_d = {rem_fix, quo_fix};
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_DIVZERO: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = {(2*WIDTH){1'b0}};
        end
      end
      S_END: begin
        if (annul || !start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_END;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered, so they trail the state by one edge
    ready_d = (state_q == S_END) && (state_d == S_END);
    busy_d  = ((state_q == S_ON) || (state_q == S_DIVZERO)) && (state_d != S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      work_q   <= {(2*WIDTH+1){1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule
